trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Parametrised successor to the single-source exception monitor: a vectored trap controller for the 5-stage core.
- Arbitrates N_IRQ maskable interrupt lines plus three synchronous ID-stage exceptions (bad instruction, illegal PC, illegal memory).
- Switches user/kernel mode, saves the return PC and cause, and supports return-from-trap.
- Sits beside the ID stage; drives PC redirect and pipeline flush.

Parameters:
N_IRQ, 4, number of interrupt lines, 1..8
EXC_VEC, 16'h0200, handler address for synchronous exceptions taken in user mode
FATAL_VEC, 16'h0300, handler address for any synchronous exception taken in kernel mode
IRQ_VEC_BASE, 16'h0030, vector of irq[0]
IRQ_VEC_STRIDE, 16'h0010, vector spacing; irq i vectors to IRQ_VEC_BASE + i*IRQ_VEC_STRIDE (16-bit, wraps)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
irq  in  N_IRQ  interrupt request lines
mask_we  in  1  write enable for the interrupt-enable mask
mask_wdata  in  N_IRQ  new mask value; 1 = enabled
bad_instr  in  1  ID-stage exception
illegal_pc  in  1  ID-stage exception
illegal_mem  in  1  ID-stage exception
mret  in  1  return-from-trap decoded in ID
cur_pc  in  16  PC of the instruction in ID
stall  in  1  pipeline stall (IF/ID held)
redirect  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  16  target address, valid while redirect = 1
flush  out  1  flush IF/ID and ID/EX; asserted together with redirect
mode  out  2  2'b00 = kernel, 2'b01 = user
epc  out  16  saved return PC
cause  out  4  0 none, 1 bad_instr, 2 illegal_pc, 3 illegal_mem, 8+i irq i
irq_ack  out  N_IRQ  one-hot one-cycle acknowledge
mask  out  N_IRQ  current enable mask
double_fault  out  1  sticky; set by an exception taken in kernel mode

Behaviour:
- Reset (rst = 0 at a clk edge): mode = 00, mask = 0, epc = 0, cause = 0, redirect/flush/irq_ack = 0, redirect_pc = 0, double_fault = 0, pending = 0, state = RUN. Reset mid-trap abandons the trap with no redirect.
- Decision cycle: any cycle with stall = 0 and state = RUN. While stall = 1, no decision is made and all state is held, except that mask writes and pending capture still occur.
- Priority, highest first: bad_instr > illegal_pc > illegal_mem > mret > enabled pending irq, lowest index first.
- Exception in user mode, decided at cycle T. At T+1:
  - redirect = flush = 1, redirect_pc = EXC_VEC.
  - epc = cur_pc sampled at T, cause = 1, 2 or 3, mode = 00.
- Exception in kernel mode:
  - redirect to FATAL_VEC, double_fault = 1.
  - cause is updated; epc and mode are unchanged.
- IRQ: taken only when mode = 01 and pending[i] & mask[i]. At T+1:
  - redirect = flush = 1, redirect_pc = vector(i).
  - epc = cur_pc (the resume point), cause = 8+i, mode = 00, irq_ack[i] = 1.
  - pending[i] clears.
- mret: honoured only in kernel mode. At T+1: redirect = flush = 1, redirect_pc = epc, mode = 01, cause = 0. An mret in user mode is ignored; ID flags it as bad_instr.
- After any redirect, state = COOL for exactly one cycle. No decision is made in COOL, then state returns to RUN. Result: at most one redirect every two cycles.
- mret and a pending IRQ in the same cycle: mret wins. The IRQ is taken at the earliest in the first RUN cycle after COOL.
- mask_we: mask updates at the clock edge. The decision in that same cycle uses the old mask.
- Pending capture, level mode: pending[i] = irq[i] sampled each cycle.
- Interrupts never nest; kernel mode blocks all IRQs.

Optional Feature:
IRQ_EDGE_EN
- Defined: pending[i] is set on a 0→1 edge of irq[i] (one registered sample of history) and held until acked or reset. A masked edge stays pending until it is enabled.
- Undefined: level-sensitive, with no latching. A request dropped before it is taken is lost.

Test Plan:
- Reset, then mask_we with 4'b0101, mode forced to user via mret with epc = 0 → redirect_pc = 0000, mode = 01; then irq = 4'b0100 with cur_pc = 16'h1234 → next cycle redirect_pc = 16'h0050, epc = 1234, cause = 10, irq_ack = 4'b0100, mode = 00.
- User mode, bad_instr and irq[0] asserted together, cur_pc = 16'h2000 → redirect_pc = 0200, cause = 1, epc = 2000, irq_ack = 0; in kernel, illegal_mem → redirect_pc = 0300, double_fault = 1, epc still 2000.
- Kernel mode, epc = 16'h2000, mret and irq[1] enabled together → redirect_pc = 2000, mode = 01; COOL cycle has no redirect; the next cycle takes irq[1] (redirect_pc = 0040).
- stall held high for 3 cycles with irq[0] enabled in user mode → no redirect during the stall; trap fires in the cycle after stall falls.
- irq[3] asserted while mask[3] = 0, then mask_we enabling it, with irq still high → taken on the cycle after the mask write; with IRQ_EDGE_EN, a 1-cycle pulse on irq[3] while masked is still taken after enabling.
- Reset asserted in the cycle after a trap decision → all outputs return to reset values, no redirect observed.

Source files
------------

// File: rtl/trap_ctrl.sv
// Vectored trap controller: arbitrates ID-stage exceptions, mret and maskable IRQs.
// Define IRQ_EDGE_EN for edge-latched pending interrupts; the default build is level-sensitive.
module trap_ctrl #(
  parameter int          N_IRQ          = 4,
  parameter logic [15:0] EXC_VEC        = 16'h0200,
  parameter logic [15:0] FATAL_VEC      = 16'h0300,
  parameter logic [15:0] IRQ_VEC_BASE   = 16'h0030,
  parameter logic [15:0] IRQ_VEC_STRIDE = 16'h0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             bad_instr,
  input  logic             illegal_pc,
  input  logic             illegal_mem,
  input  logic             mret,
  input  logic [15:0]      cur_pc,
  input  logic             stall,
  output logic             redirect,
  output logic [15:0]      redirect_pc,
  output logic             flush,
  output logic [1:0]       mode,
  output logic [15:0]      epc,
  output logic [3:0]       cause,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [N_IRQ-1:0] mask,
  output logic             double_fault
);

  typedef enum logic {RUN, COOL} state_t;

  localparam logic [1:0] MODE_KERNEL = 2'b00;
  localparam logic [1:0] MODE_USER   = 2'b01;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      epc_q, epc_d;
  logic [3:0]       cause_q, cause_d;
  logic             double_fault_q, double_fault_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             redirect_q, redirect_d;
  logic             flush_q, flush_d;
  logic [15:0]      redirect_pc_q, redirect_pc_d;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;

  logic [N_IRQ-1:0] pending_eff;
  logic [N_IRQ-1:0] irq_take;
  logic [N_IRQ-1:0] irq_sel;
  logic [2:0]       irq_idx;
  logic             irq_found;
  logic             exc_hit;
  logic [3:0]       exc_cause;

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;

  // A rising edge counts in the cycle it appears, then stays latched until acked.
  always_comb begin
    pending_eff = pending_q | (irq & ~irq_prev_q);
    irq_prev_d  = irq;
    pending_d   = pending_eff & ~irq_ack_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q  <= '0;
      irq_prev_q <= '0;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
    end
  end
`else
  always_comb begin
    pending_eff = irq;
  end
`endif

  always_comb begin
    irq_take  = pending_eff & mask_q;
    irq_sel   = '0;
    irq_idx   = '0;
    irq_found = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_take[i] && !irq_found) begin
        irq_found  = 1'b1;
        irq_idx    = 3'(i);
        irq_sel[i] = 1'b1;
      end
    end

    exc_hit   = bad_instr | illegal_pc | illegal_mem;
    exc_cause = bad_instr ? 4'd1 : (illegal_pc ? 4'd2 : 4'd3);
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    double_fault_d = double_fault_q;
    mask_d         = mask_we ? mask_wdata : mask_q;
    redirect_d     = 1'b0;
    flush_d        = 1'b0;
    redirect_pc_d  = '0;
    irq_ack_d      = '0;

    if (!stall) begin
      if (state_q == COOL) begin
        state_d = RUN;
      end else if (exc_hit) begin
        redirect_d = 1'b1;
        flush_d    = 1'b1;
        cause_d    = exc_cause;
        state_d    = COOL;
        if (mode_q == MODE_USER) begin
          redirect_pc_d = EXC_VEC;
          epc_d         = cur_pc;
          mode_d        = MODE_KERNEL;
        end else begin
          redirect_pc_d  = FATAL_VEC;
          double_fault_d = 1'b1;
        end
      end else if (mret && mode_q == MODE_KERNEL) begin
        redirect_d    = 1'b1;
        flush_d       = 1'b1;
        redirect_pc_d = epc_q;
        mode_d        = MODE_USER;
        cause_d       = 4'd0;
        state_d       = COOL;
      end else if (mode_q == MODE_USER && irq_found) begin
        redirect_d    = 1'b1;
        flush_d       = 1'b1;
        redirect_pc_d = IRQ_VEC_BASE + 16'(irq_idx) * IRQ_VEC_STRIDE;
        epc_d         = cur_pc;
        cause_d       = 4'd8 + {1'b0, irq_idx};
        mode_d        = MODE_KERNEL;
        irq_ack_d     = irq_sel;
        state_d       = COOL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      mode_q         <= MODE_KERNEL;
      epc_q          <= '0;
      cause_q        <= '0;
      double_fault_q <= 1'b0;
      mask_q         <= '0;
      redirect_q     <= 1'b0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
      irq_ack_q      <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      double_fault_q <= double_fault_d;
      mask_q         <= mask_d;
      redirect_q     <= redirect_d;
      flush_q        <= flush_d;
      redirect_pc_q  <= redirect_pc_d;
      irq_ack_q      <= irq_ack_d;
    end
  end

  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign flush        = flush_q;
  assign mode         = mode_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign irq_ack      = irq_ack_q;
  assign mask         = mask_q;
  assign double_fault = double_fault_q;

endmodule
